key_click_classifier: RTL and testbench
=======================================

Name: key_click_classifier

Overview:
Downstream consumer of the key debounce stage. Takes the debounced one-clock key-press pulse and counts presses that occur within a sliding time window. When the window expires, or the count saturates, it reports a click event: single, double or triple. The report drives the mode/LED control logic in place of raw press pulses.

Parameters:
T1MS, 16'd49_999, prescaler terminal count for a 1 ms tick (50 MHz CLK); prescaler counts 0..T1MS.
WIN_MS, 9'd300, click window in ms, range 1..511; restarted on every accepted press.
MAX_CLICKS, 2'd3, saturating click count, range 1..3; reaching it reports immediately.

Ports:
CLK  in  1  system clock, rising edge.
RST_n  in  1  reset; asynchronous, active-low.
Key_Pulse  in  1  debounced press pulse, one CLK wide; from the debounce stage.
Click_Valid  out  1  one-CLK pulse: click event ready.
Click_Cnt  out  2  number of presses in the event (1..MAX_CLICKS); holds until the next report.
Busy  out  1  high while a window is open (states WAIT and REPORT).

Behaviour:
- Reset (async, any state): state=IDLE, prescaler=0, ms_cnt=0, press count=0, Click_Valid=0, Click_Cnt=0, Busy=0.
- Timer:
  - 16-bit prescaler and 9-bit ms_cnt run only in WAIT.
  - The prescaler wraps at T1MS; ms_cnt increments on each wrap.
  - Both are cleared to 0 on entry to WAIT and on every accepted press.
- FSM states: IDLE, WAIT, REPORT.
- IDLE:
  - Key_Pulse=1 -> count=1, clear timer.
  - Next state is REPORT if MAX_CLICKS==1, else WAIT.
- WAIT:
  - Key_Pulse=1 and count+1==MAX_CLICKS -> count=MAX_CLICKS, go REPORT.
  - Key_Pulse=1 otherwise -> count+1, clear timer, stay in WAIT (window restarts).
  - No pulse and ms_cnt reaches WIN_MS -> go REPORT. The transition happens on the edge where the prescaler wraps with ms_cnt==WIN_MS-1.
  - Pulse and timeout on the same edge: the pulse wins. It is counted (or saturates) and the window restarts.
- REPORT (exactly one cycle):
  - Click_Valid=1; Click_Cnt=count, registered on the edge entering REPORT.
  - Next state IDLE; count cleared.
  - A Key_Pulse arriving in REPORT is dropped. This cannot occur behind the 20 ms debounce stage.
- Latency: the last press is sampled at edge E0. For a timeout report, Click_Valid is high during the cycle that starts WIN_MS*(T1MS+1) edges after E0. For a saturating report, Click_Valid is high during the cycle after E0.
- Outputs: all registered; no combinational input-to-output path.
- Busy is high in WAIT and REPORT and low in IDLE.
- Click_Cnt keeps its value after Click_Valid drops; it changes only at the next report.

Decomposition:
- Shared package key_pkg:
  - FSM state encoding ST_IDLE=2'd0, ST_WAIT=2'd1, ST_REPORT=2'd2.
  - Default T1MS.
  - Click-count width constant CLICK_W=2.
- Sub-module ms_tick_gen: prescaler plus ms counter.
  - Inputs: enable, sync clear.
  - Outputs: ms_cnt, tick.
  - Param T1MS, reused by the debounce stage.
- Top: FSM, count register, output registers.

Test Plan (T1MS=9, WIN_MS=5, i.e. 50-cycle window; MAX_CLICKS=3 unless stated):
- Single press at cycle 10 -> Busy high from cycle 11; Click_Valid=1, Click_Cnt=1 in exactly one cycle, 50 cycles after the sampling edge; then IDLE, Busy=0.
- Presses at cycles 10 and 40 -> the second press restarts the window; one report with Click_Cnt=2, 50 cycles after cycle 40; no report in between.
- Presses at 10, 30, 45 -> report with Click_Cnt=3 in the cycle after 45 (saturation); no later timeout report.
- Second press aligned to the exact timeout edge -> no report at that edge; count=2; new window; report Click_Cnt=2 50 cycles later.
- RST_n pulsed low mid-WAIT after 2 presses -> all outputs 0 immediately; no report ever issues for those presses; a subsequent single press reports Click_Cnt=1.
- MAX_CLICKS=1, press at 10 -> Click_Valid=1, Click_Cnt=1 in the next cycle; Click_Cnt still 1 a hundred cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key handling blocks (debounce, click classifier).
// Contents:
//   ST_IDLE / ST_WAIT / ST_REPORT : classifier FSM state encoding
//   T1MS_DEFAULT                  : prescaler terminal count for a 1 ms tick at 50 MHz
//   CLICK_W                       : width of the click count
//   MS_W                          : width of the millisecond counter
package key_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam logic [15:0] T1MS_DEFAULT = 16'd49_999;

  localparam int CLICK_W = 2;
  localparam int MS_W    = 9;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond time base: a 16-bit prescaler counting 0..T1MS and a
// millisecond counter that advances each time the prescaler wraps.
// Ports:
//   CLK, RST_n : clock, asynchronous active-low reset
//   en         : count while high, hold while low
//   clr        : synchronous clear of prescaler and ms counter (wins over en)
//   ms_cnt     : completed milliseconds since the last clear
//   tick       : high in the cycle whose rising edge wraps the prescaler
module ms_tick_gen
  import key_pkg::*;
#(
  parameter logic [15:0] T1MS = T1MS_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            en,
  input  logic            clr,
  output logic [MS_W-1:0] ms_cnt,
  output logic            tick
);

  logic [15:0] presc;

  // Announces the wrap one cycle ahead so the consumer can act on the same
  // edge that bumps ms_cnt.
  assign tick = en && (presc == T1MS);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (clr) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (en) begin
      if (presc == T1MS) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 1'b1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

endmodule

// File: rtl/key_click_classifier.sv
// Groups debounced key presses into single / double / triple click events.
// A press opens (or restarts) a WIN_MS window; the event is reported when the
// window expires or as soon as MAX_CLICKS presses have been collected.
// Ports:
//   CLK, RST_n  : clock, asynchronous active-low reset
//   Key_Pulse   : one-cycle debounced press pulse
//   Click_Valid : one-cycle pulse, a click event is reported
//   Click_Cnt   : presses in the last event (1..MAX_CLICKS), held until next event
//   Busy        : high while a window is open or a report is being issued
module key_click_classifier
  import key_pkg::*;
#(
  parameter logic [15:0] T1MS       = T1MS_DEFAULT,
  parameter logic [8:0]  WIN_MS     = 9'd300,
  parameter logic [1:0]  MAX_CLICKS = 2'd3
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               Key_Pulse,
  output logic               Click_Valid,
  output logic [CLICK_W-1:0] Click_Cnt,
  output logic               Busy
);

  logic [1:0]         state, state_next;
  logic [CLICK_W-1:0] count, count_next;
  logic               timer_clr;
  logic               tick;
  logic [MS_W-1:0]    ms_cnt;

  // Timer only runs in WAIT; it is zeroed by every accepted press, which also
  // covers entry into WAIT (the only way in is a press from IDLE).
  ms_tick_gen #(.T1MS(T1MS)) u_tick (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .en     (state == ST_WAIT),
    .clr    (timer_clr),
    .ms_cnt (ms_cnt),
    .tick   (tick)
  );

  // Window expiry: the prescaler wraps while the last full millisecond is running.
  logic timeout;
  assign timeout = tick && (ms_cnt == MS_W'(WIN_MS - 9'd1));

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    timer_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Key_Pulse) begin
          count_next = CLICK_W'(1);
          timer_clr  = 1'b1;
          state_next = (MAX_CLICKS == 2'd1) ? ST_REPORT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A press beats a simultaneous timeout: it is counted and restarts the window.
        if (Key_Pulse) begin
          if (count + CLICK_W'(1) == MAX_CLICKS) begin
            count_next = MAX_CLICKS;
            state_next = ST_REPORT;
          end else begin
            count_next = count + CLICK_W'(1);
            timer_clr  = 1'b1;
          end
        end else if (timeout) begin
          state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        // Presses here are dropped; the debounce stage cannot produce them this close.
        state_next = ST_IDLE;
        count_next = '0;
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they are registered yet line up
  // with the state they describe.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      Click_Valid <= 1'b0;
      Click_Cnt   <= '0;
      Busy        <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      Click_Valid <= (state_next == ST_REPORT);
      Busy        <= (state_next != ST_IDLE);
      if (state_next == ST_REPORT) begin
        Click_Cnt <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_key_click_classifier.sv
// Self-checking bench for key_click_classifier. Two instances share the clock
// and reset: dut0 saturates at 3 clicks, dut1 at 1 click. Both use a 50-cycle
// window (T1MS=9, WIN_MS=5). Expected outputs come from an event/deadline model
// of the click rules, compared every cycle #1 after the rising edge.
module tb_key_click_classifier;

  localparam logic [15:0] T1MS   = 16'd9;
  localparam logic [8:0]  WIN_MS = 9'd5;
  localparam int          WINDOW = 50;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       kp0, kp1;
  logic       v0, v1, b0, b1;
  logic [1:0] c0, c1;

  always #5 CLK = ~CLK;

  key_click_classifier #(.T1MS(T1MS), .WIN_MS(WIN_MS), .MAX_CLICKS(2'd3)) dut0 (
    .CLK(CLK), .RST_n(RST_n), .Key_Pulse(kp0),
    .Click_Valid(v0), .Click_Cnt(c0), .Busy(b0)
  );

  key_click_classifier #(.T1MS(T1MS), .WIN_MS(WIN_MS), .MAX_CLICKS(2'd1)) dut1 (
    .CLK(CLK), .RST_n(RST_n), .Key_Pulse(kp1),
    .Click_Valid(v1), .Click_Cnt(c1), .Busy(b1)
  );

  logic [3:0] obs [2];
  always_comb begin
    obs[0] = {v0, c0, b0};
    obs[1] = {v1, c1, b1};
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per instance, press count, window deadline (edge index),
  // whether a window is open, whether this cycle is a report, and last report.
  int edge_n;
  int m_cnt   [2];
  int m_dl    [2];
  int m_click [2];
  bit m_open  [2];
  bit m_rep   [2];
  int max_c   [2] = '{3, 1};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_dl[k] = 0; m_click[k] = 0; m_open[k] = 0; m_rep[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit kp);
    if (m_rep[k]) begin
      m_rep[k] = 0;  // press during the report cycle is lost
      m_cnt[k] = 0;
    end else if (!m_open[k]) begin
      if (kp) begin
        m_cnt[k] = 1;
        if (max_c[k] == 1) begin
          m_rep[k] = 1; m_click[k] = 1;
        end else begin
          m_open[k] = 1; m_dl[k] = edge_n + WINDOW;
        end
      end
    end else if (kp) begin
      m_cnt[k]++;
      if (m_cnt[k] == max_c[k]) begin
        m_rep[k] = 1; m_click[k] = m_cnt[k]; m_open[k] = 0;
      end else begin
        m_dl[k] = edge_n + WINDOW;
      end
    end else if (edge_n == m_dl[k]) begin
      m_rep[k] = 1; m_click[k] = m_cnt[k]; m_open[k] = 0;
    end
  endtask

  function automatic logic [3:0] exp_vec(input int k);
    return {m_rep[k], 2'(m_click[k]), m_open[k] | m_rep[k]};
  endfunction

  // One clock: apply inputs, let the edge happen, advance the model, settle.
  task automatic step(input bit p0, input bit p1);
    kp0 = p0;
    kp1 = p1;
    @(posedge CLK);
    edge_n++;
    model_edge(0, p0);
    model_edge(1, p1);
    #1;
  endtask

  task automatic test_reset();
    RST_n = 1'b0; kp0 = 1'b0; kp1 = 1'b0;
    edge_n = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset dut%0d: got v/cnt/busy=%b need 0000", k, obs[k]);
      end
    end
    RST_n = 1'b1;
  endtask

  task automatic test_single();
    int reports = 0;
    for (int i = 0; i < 70; i++) begin
      step(i == 10, 1'b0);
      if (v0) reports++;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL single dut%0d cyc %0d: got %b need %b", k, i, obs[k], exp_vec(k));
        end
      end
    end
    n_checks++;
    if (reports !== 1) begin
      n_errors++;
      $display("FAIL single_report_count: got %0d need 1", reports);
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 95; i++) begin
      step(i == 0 || i == 30, 1'b0);
      n_checks++;
      if (obs[0] !== exp_vec(0)) begin
        n_errors++;
        $display("FAIL restart cyc %0d: got %b need %b", i, obs[0], exp_vec(0));
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 100; i++) begin
      step(i == 0 || i == 20 || i == 35, 1'b0);
      n_checks++;
      if (obs[0] !== exp_vec(0)) begin
        n_errors++;
        $display("FAIL saturate cyc %0d: got %b need %b", i, obs[0], exp_vec(0));
      end
    end
  endtask

  // Second press lands on exactly the edge where the window would expire.
  task automatic test_collision();
    for (int i = 0; i < 110; i++) begin
      step(i == 0 || i == WINDOW, 1'b0);
      n_checks++;
      if (obs[0] !== exp_vec(0)) begin
        n_errors++;
        $display("FAIL collision cyc %0d: got %b need %b", i, obs[0], exp_vec(0));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 20; i++) step(i == 0 || i == 10, 1'b0);
    RST_n = 1'b0;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 4'b0000) begin
        n_errors++;
        $display("FAIL async_reset dut%0d: got %b need 0000", k, obs[k]);
      end
    end
    #1;
    RST_n = 1'b1;
    for (int i = 0; i < 130; i++) begin
      step(i == 70, 1'b0);
      n_checks++;
      if (obs[0] !== exp_vec(0)) begin
        n_errors++;
        $display("FAIL reset_mid_wait cyc %0d: got %b need %b", i, obs[0], exp_vec(0));
      end
    end
  endtask

  task automatic test_max1();
    for (int i = 0; i < 110; i++) begin
      step(1'b0, i == 10);
      n_checks++;
      if (obs[1] !== exp_vec(1)) begin
        n_errors++;
        $display("FAIL max1 cyc %0d: got %b need %b", i, obs[1], exp_vec(1));
      end
    end
    n_checks++;
    if (c1 !== 2'd1) begin
      n_errors++;
      $display("FAIL max1_hold: got %0d need 1", c1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 17) == 0, $urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL random dut%0d cyc %0d: got %b need %b", k, i, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_restart();
    test_saturate();
    test_collision();
    test_reset_mid_wait();
    test_max1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
